// File: rtl/inst_encoder_if.sv
// inst_encoder_if: request and instruction-word stream channels of the
// instruction encoder. The request channel carries decoded fields with a
// valid/ready handshake. The output channel carries encoded words with their
// target addresses. The slave modport is the encoder side. The master modport
// is the producer/sink side.
interface inst_encoder_if #(
  parameter int ADDR_W = 8
) ();
  // request channel
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        fmt;
  logic [4:0]        rd;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [2:0]        funct3;
  logic              f7b5;
  logic [31:0]       imm;
  // encoded word channel
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_data;
  logic [ADDR_W-1:0] out_addr;

  modport master (
    output in_valid, fmt, rd, rs1, rs2, funct3, f7b5, imm,
    input  in_ready,
    input  out_valid, out_data, out_addr,
    output out_ready
  );

  modport slave (
    input  in_valid, fmt, rd, rs1, rs2, funct3, f7b5, imm,
    output in_ready,
    output out_valid, out_data, out_addr,
    input  out_ready
  );
endinterface

// File: rtl/inst_encoder.sv
// inst_encoder: packs decoded-field requests into RV32I instruction words and
// streams them, tagged with consecutive wrapping word addresses, to the
// instruction-memory write port. A load is started by a start pulse and covers
// prog_len accepted requests.
// Optional feature macro: IMM_CHECK_EN. When it is defined, immediates are
// range-checked per format. Out-of-range requests are consumed but dropped,
// and they are reported through err/err_cnt. When it is not defined, err and
// err_cnt are tied low.
module inst_encoder #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   prog_len,
  inst_encoder_if.slave     bus,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [7:0]        err_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  // Packs one request into an RV32I word; unused fields stay zero.
  function automatic logic [31:0] encode_word(
    input logic [2:0]  fmt_i,
    input logic [4:0]  rd_i,
    input logic [4:0]  rs1_i,
    input logic [4:0]  rs2_i,
    input logic [2:0]  f3_i,
    input logic        f7b5_i,
    input logic [31:0] imm_i
  );
    logic [31:0] w;
    case (fmt_i)
      3'd0:    w = {1'b0, f7b5_i, 5'b00000, rs2_i, rs1_i, f3_i, rd_i, 7'b0110011};
      3'd1:    w = {imm_i[11:0], rs1_i, f3_i, rd_i, 7'b0010011};
      3'd2:    w = {imm_i[11:0], rs1_i, f3_i, rd_i, 7'b0000011};
      3'd3:    w = {imm_i[11:5], rs2_i, rs1_i, f3_i, imm_i[4:0], 7'b0100011};
      3'd4:    w = {imm_i[31:12], rd_i, 7'b0110111};
      3'd5:    w = {imm_i[31:12], rd_i, 7'b0010111};
      3'd6:    w = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, f3_i, imm_i[4:1],
                    imm_i[11], 7'b1100011};
      3'd7:    w = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i,
                    7'b1101111};
      default: w = 32'h0000_0000;
    endcase
    return w;
  endfunction

`ifdef IMM_CHECK_EN
  // True when the immediate fits the field of the given format without loss.
  function automatic logic imm_in_range(
    input logic [2:0]  fmt_i,
    input logic [31:0] imm_i
  );
    logic ok;
    case (fmt_i)
      3'd1, 3'd2, 3'd3: ok = (&imm_i[31:11]) | ~(|imm_i[31:11]);
      3'd6:             ok = ((&imm_i[31:12]) | ~(|imm_i[31:12])) & ~imm_i[0];
      3'd7:             ok = ((&imm_i[31:20]) | ~(|imm_i[31:20])) & ~imm_i[0];
      3'd4, 3'd5:       ok = ~(|imm_i[11:0]);
      default:          ok = 1'b1;
    endcase
    return ok;
  endfunction
`endif

  state_t            state_r;
  logic [ADDR_W:0]   acc_cnt_r;
  logic [ADDR_W:0]   len_r;
  logic [ADDR_W-1:0] base_r;
  logic [ADDR_W-1:0] wr_ptr_r;
  logic              out_valid_r;
  logic [31:0]       out_data_r;
  logic [ADDR_W-1:0] out_addr_r;

  logic              start_ok_s;
  logic              in_ready_s;
  logic              in_fire_s;
  logic              out_fire_s;
  logic              emit_s;
  logic [31:0]       word_s;
  logic [ADDR_W:0]   acc_nxt_s;

  assign start_ok_s = start && (state_r == ST_IDLE);
  // The single output slot can take a new word when it is empty or being drained this cycle.
  assign in_ready_s = (state_r == ST_RUN) && (acc_cnt_r < len_r) &&
                      (!out_valid_r || bus.out_ready);
  assign in_fire_s  = bus.in_valid && in_ready_s;
  assign out_fire_s = out_valid_r && bus.out_ready;
  assign acc_nxt_s  = acc_cnt_r + CNT_ONE;
  assign word_s     = encode_word(bus.fmt, bus.rd, bus.rs1, bus.rs2, bus.funct3,
                                  bus.f7b5, bus.imm);
`ifdef IMM_CHECK_EN
  assign emit_s     = imm_in_range(bus.fmt, bus.imm);
`else
  assign emit_s     = 1'b1;
`endif

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_addr  = out_addr_r;
  assign busy          = (state_r != ST_IDLE);
  assign done          = (state_r == ST_DONE);

  // Load sequencing: start/length capture, accepted-request counting, drain and done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      acc_cnt_r <= {(ADDR_W+1){1'b0}};
      len_r     <= {(ADDR_W+1){1'b0}};
      base_r    <= {ADDR_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            base_r    <= base_addr;
            len_r     <= prog_len;
            acc_cnt_r <= {(ADDR_W+1){1'b0}};
            state_r   <= (prog_len == {(ADDR_W+1){1'b0}}) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (in_fire_s) begin
            acc_cnt_r <= acc_nxt_s;
            if (acc_nxt_s == len_r) begin
              state_r <= ST_DRAIN;
            end
          end
        end
        // Leave as soon as the slot empties, so done follows the last output handshake directly.
        ST_DRAIN: begin
          if (!out_valid_r || out_fire_s) begin
            state_r <= ST_DONE;
          end
        end
        ST_DONE: state_r <= ST_IDLE;
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // One-entry output slot and write pointer; a new word may replace one leaving the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r    <= {ADDR_W{1'b0}};
      out_valid_r <= 1'b0;
      out_data_r  <= 32'h0000_0000;
      out_addr_r  <= {ADDR_W{1'b0}};
    end else begin
      if (start_ok_s) begin
        wr_ptr_r <= {ADDR_W{1'b0}};
      end
      if (in_fire_s && emit_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= word_s;
        out_addr_r  <= base_r + wr_ptr_r;
        wr_ptr_r    <= wr_ptr_r + PTR_ONE;
      end else if (out_fire_s) begin
        out_valid_r <= 1'b0;
      end
    end
  end

`ifdef IMM_CHECK_EN
  logic       err_r;
  logic [7:0] err_cnt_r;

  // Sticky range error flag and saturating drop counter, cleared by an accepted start.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_r     <= 1'b0;
      err_cnt_r <= 8'h00;
    end else if (start_ok_s) begin
      err_r     <= 1'b0;
      err_cnt_r <= 8'h00;
    end else if (in_fire_s && !emit_s) begin
      err_r <= 1'b1;
      if (err_cnt_r != 8'hFF) begin
        err_cnt_r <= err_cnt_r + 8'h01;
      end
    end
  end

  assign err     = err_r;
  assign err_cnt = err_cnt_r;
`else
  assign err     = 1'b0;
  assign err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder: directed bench for inst_encoder. A per-cycle monitor
// compares the output stream and in_ready against a field-level model of the
// encoding rules. Directed sections pin the model with hand-computed words,
// addresses and done/busy timing.
module tb_inst_encoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] base_addr = 8'h00;
  logic [8:0] prog_len = 9'd0;
  logic       busy, done, err;
  logic [7:0] err_cnt;

  inst_encoder_if #(.ADDR_W(8)) bus ();

  inst_encoder #(.ADDR_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .prog_len  (prog_len),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic [7:0]  a;
  } exp_t;

  exp_t        q[$];
  logic [31:0] log_d[$];
  logic [7:0]  log_a[$];
  int          log_c[$];
  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          cyc = 0;
  bit          tb_end = 1'b0;
  bit          m_run = 1'b0;
  int          m_left = 0;
  logic [7:0]  m_base = 8'h00;
  logic [7:0]  m_ptr = 8'h00;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  // Model: build the word field by field from the format tables.
  function automatic logic [31:0] m_enc(input logic [2:0] f, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
      input logic b5, input logic [31:0] imm);
    logic [6:0]  opc_tbl [8] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h37, 7'h17, 7'h63, 7'h6F};
    logic [31:0] w;
    w = {25'd0, opc_tbl[f]};
    if (f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd7}) w = w | ({27'd0, rd} << 7);
    if (f inside {3'd0, 3'd1, 3'd2, 3'd3, 3'd6})
      w = w | ({27'd0, rs1} << 15) | ({29'd0, f3} << 12);
    if (f inside {3'd0, 3'd3, 3'd6}) w = w | ({27'd0, rs2} << 20);
    if (f == 3'd0) w = w | ({31'd0, b5} << 30);
    if (f inside {3'd1, 3'd2}) w = w | ((imm & 32'h0000_0FFF) << 20);
    if (f == 3'd3) w = w | (((imm >> 5) & 32'h7F) << 25) | ((imm & 32'h1F) << 7);
    if (f inside {3'd4, 3'd5}) w = w | (imm & 32'hFFFF_F000);
    if (f == 3'd6)
      w = w | (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) |
              (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7);
    if (f == 3'd7)
      w = w | (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
              (((imm >> 11) & 32'h1) << 20) | (imm & 32'h000F_F000);
    return w;
  endfunction

  // Model: does the immediate survive the format's field (only with the check enabled)?
  function automatic bit m_ok(input logic [2:0] f, input logic [31:0] imm);
`ifdef IMM_CHECK_EN
    int s;
    s = $signed(imm);
    case (f)
      3'd1, 3'd2, 3'd3: return (s >= -2048) && (s <= 2047);
      3'd6:             return (s >= -4096) && (s <= 4095) && (imm[0] == 1'b0);
      3'd7:             return (s >= -1048576) && (s <= 1048575) && (imm[0] == 1'b0);
      3'd4, 3'd5:       return (imm % 32'd4096) == 32'd0;
      default:          return 1'b1;
    endcase
`else
    return (f == f) && (imm == imm);
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] b, input logic [8:0] l);
    start = 1'b1; base_addr = b; prog_len = l;
    tick();
    start = 1'b0;
    m_base = b; m_ptr = 8'h00; m_left = int'(l); m_run = (l != 9'd0);
  endtask

  task automatic send(input logic [2:0] f, input logic [4:0] rd, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [2:0] f3, input logic b5, input logic [31:0] imm);
    bit acc;
    acc = 1'b0;
    bus.fmt = f; bus.rd = rd; bus.rs1 = rs1; bus.rs2 = rs2;
    bus.funct3 = f3; bus.f7b5 = b5; bus.imm = imm; bus.in_valid = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      acc = bus.in_ready;
      tick();
      if (acc) break;
    end
    if (!acc) chk("send_timeout", 32'(acc), 32'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
    end
    chk("done_seen", 32'(seen), 32'd1);
    tick();
    @(negedge clk);
    chk("done_drop", 32'(done), 32'd0);
    chk("busy_drop", 32'(busy), 32'd0);
    tick();
  endtask

  // Compare process: stream contents, out_valid and in_ready against the model every cycle.
  task automatic monitor();
    bit exp_rdy;
    while (!tb_end) begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        q.delete(); m_run = 1'b0; m_left = 0;
      end else begin
        exp_rdy = m_run && (m_left > 0) && ((q.size() == 0) || bus.out_ready);
        chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
        chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        if (bus.out_valid && q.size() > 0) begin
          chk("out_data", bus.out_data, q[0].d);
          chk("out_addr", 32'(bus.out_addr), 32'(q[0].a));
          if (bus.out_ready) begin
            log_d.push_back(bus.out_data); log_a.push_back(bus.out_addr);
            log_c.push_back(cyc); void'(q.pop_front());
          end
        end
        if (bus.in_valid && bus.in_ready) begin
          m_left--;
          if (m_ok(bus.fmt, bus.imm)) begin
            q.push_back('{d: m_enc(bus.fmt, bus.rd, bus.rs1, bus.rs2, bus.funct3,
                                   bus.f7b5, bus.imm), a: m_base + m_ptr});
            m_ptr = m_ptr + 8'd1;
          end
        end
      end
    end
  endtask

  task automatic run_tests();
    int li;
    logic [31:0] exp_w [4] = '{32'h0020A423, 32'hFE208EE3, 32'h123452B7, 32'h008000EF};
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.fmt = 3'd0; bus.rd = 5'd0;
    bus.rs1 = 5'd0; bus.rs2 = 5'd0; bus.funct3 = 3'd0; bus.f7b5 = 1'b0; bus.imm = 32'd0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", bus.out_data, 32'd0);
    chk("rst_out_addr", 32'(bus.out_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // single addi; done one cycle after the output handshake
    do_start(8'h00, 9'd1);
    @(negedge clk);
    chk("start_busy", 32'(busy), 32'd1);
    tick();
    send(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5);
    @(negedge clk);
    chk("addi_data", bus.out_data, 32'h00500093);
    chk("addi_addr", 32'(bus.out_addr), 32'd0);
    chk("addi_done_early", 32'(done), 32'd0);
    tick();
    @(negedge clk);
    chk("addi_done", 32'(done), 32'd1);
    tick();
    @(negedge clk);
    chk("addi_idle", 32'(busy), 32'd0);
    tick();

    // back-to-back stream of four formats
    do_start(8'h10, 9'd4);
    li = log_d.size();
    send(3'd3, 5'd0, 5'd1, 5'd2, 3'd2, 1'b0, 32'd8);
    send(3'd6, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'hFFFF_FFFC);
    send(3'd4, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'h1234_5000);
    send(3'd7, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd8);
    wait_done();
    chk("stream_cnt", 32'(log_d.size() - li), 32'd4);
    if (log_d.size() - li == 4) begin
      for (int k = 0; k < 4; k++) begin
        chk("stream_data", log_d[li+k], exp_w[k]);
        chk("stream_addr", 32'(log_a[li+k]), 32'h10 + 32'(k));
        if (k > 0) chk("stream_gap", 32'(log_c[li+k] - log_c[li+k-1]), 32'd1);
      end
    end

    // backpressure: held word stays stable, release accepts next same cycle
    do_start(8'h20, 9'd2);
    bus.out_ready = 1'b0;
    send(3'd1, 5'd2, 5'd0, 5'd0, 3'd0, 1'b0, 32'd7);
    bus.fmt = 3'd1; bus.rd = 5'd3; bus.rs1 = 5'd0; bus.funct3 = 3'd0;
    bus.imm = 32'hFFFF_FFFF; bus.in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_data", bus.out_data, 32'h00700113);
      chk("bp_addr", 32'(bus.out_addr), 32'h20);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      tick();
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("bp_next_data", bus.out_data, 32'hFFF00193);
    chk("bp_next_addr", 32'(bus.out_addr), 32'h21);
    wait_done();

    // address wrap with add/sub
    do_start(8'hFF, 9'd2);
    li = log_d.size();
    send(3'd0, 5'd1, 5'd2, 5'd3, 3'd0, 1'b0, 32'd0);
    send(3'd0, 5'd1, 5'd2, 5'd3, 3'd0, 1'b1, 32'd0);
    wait_done();
    chk("wrap_cnt", 32'(log_d.size() - li), 32'd2);
    if (log_d.size() - li == 2) begin
      chk("wrap_add", log_d[li], 32'h003100B3);
      chk("wrap_sub", log_d[li+1], 32'h403100B3);
      chk("wrap_a0", 32'(log_a[li]), 32'hFF);
      chk("wrap_a1", 32'(log_a[li+1]), 32'h00);
    end

    // zero-length load
    do_start(8'h33, 9'd0);
    @(negedge clk);
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_valid", 32'(bus.out_valid), 32'd0);
    tick();
    @(negedge clk);
    chk("zero_done_drop", 32'(done), 32'd0);
    chk("zero_busy_drop", 32'(busy), 32'd0);
    tick();

    // immediate range: 4096 does not fit an I-type field
    do_start(8'h00, 9'd2);
    li = log_d.size();
    send(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd4096);
    send(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd1);
    wait_done();
`ifdef IMM_CHECK_EN
    chk("imm_err", 32'(err), 32'd1);
    chk("imm_err_cnt", 32'(err_cnt), 32'd1);
    chk("imm_cnt", 32'(log_d.size() - li), 32'd1);
    if (log_d.size() - li == 1) begin
      chk("imm_data", log_d[li], 32'h00100093);
      chk("imm_addr", 32'(log_a[li]), 32'h00);
    end
`else
    chk("imm_err", 32'(err), 32'd0);
    chk("imm_err_cnt", 32'(err_cnt), 32'd0);
    chk("imm_cnt", 32'(log_d.size() - li), 32'd2);
    if (log_d.size() - li == 2) begin
      chk("imm_trunc", log_d[li], 32'h00000093);
      chk("imm_addr0", 32'(log_a[li]), 32'h00);
      chk("imm_data1", log_d[li+1], 32'h00100093);
      chk("imm_addr1", 32'(log_a[li+1]), 32'h01);
    end
`endif

    // reset while a word is pending
    do_start(8'h40, 9'd3);
    chk("start_clears_err", 32'(err), 32'd0);
    bus.out_ready = 1'b0;
    send(3'd4, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'h1234_5000);
    @(negedge clk);
    chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    tick();
    reset = 1'b1;
    tick();
    @(negedge clk);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_data", bus.out_data, 32'd0);
    chk("mid_rst_addr", 32'(bus.out_addr), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    tick();
    reset = 1'b0;
    bus.out_ready = 1'b1;
    tick();

    // start pulse while busy is ignored
    do_start(8'h50, 9'd2);
    li = log_d.size();
    send(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5);
    start = 1'b1; base_addr = 8'h60; prog_len = 9'd0;
    tick();
    start = 1'b0;
    send(3'd1, 5'd2, 5'd0, 5'd0, 3'd0, 1'b0, 32'd7);
    wait_done();
    chk("busy_start_cnt", 32'(log_d.size() - li), 32'd2);
    if (log_d.size() - li == 2) begin
      chk("busy_start_a0", 32'(log_a[li]), 32'h50);
      chk("busy_start_a1", 32'(log_a[li+1]), 32'h51);
      chk("busy_start_d1", log_d[li+1], 32'h00700113);
    end
    repeat (2) tick();
    tb_end = 1'b1;
  endtask

  initial begin
    fork
      monitor();
      run_tests();
    join
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/inst_encoder.md
# inst_encoder

Instruction encoder and program streamer: accepts decoded-field requests (format, register indices, funct bits, immediate), packs them into 32-bit RV32I instruction words and streams them with valid/ready handshaking, tagged with consecutive write addresses, to the instruction-memory write port. It is the writer-side counterpart to the instruction decoder. Testbenches and the boot loader use it to build programs in instruction memory.

## Interface
- ADDR_W, 8, instruction-memory word-address width; addresses wrap modulo 2^ADDR_W
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse, begins a program load; ignored unless state is IDLE
- base_addr  in  ADDR_W  first word address, sampled on start
- prog_len  in  ADDR_W+1  number of requests to accept, sampled on start
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready at rising edge
- fmt  in  3  0=R, 1=I-arith, 2=I-load, 3=S, 4=LUI, 5=AUIPC, 6=B, 7=J
- rd, rs1, rs2  in  5 each  register indices
- funct3  in  3  instruction bits [14:12]
- f7b5  in  1  instruction bit 30, R-type only
- imm  in  32  byte-offset / value immediate, two's complement
- out_valid  out  1  encoded word valid
- out_ready  in  1  sink accepts word when out_valid && out_ready
- out_data  out  32  encoded instruction
- out_addr  out  ADDR_W  word address for out_data
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at end of load
- err  out  1  sticky immediate-range error, cleared on start (IMM_CHECK_EN only)
- err_cnt  out  8  saturating count of dropped requests (IMM_CHECK_EN only)

## Operation
- Opcode by fmt: 0110011, 0010011, 0000011, 0100011, 0110111, 0010111, 1100011, 1101111.
- Field packing: rd→[11:7] (R, I, U, J); rs1→[19:15] and funct3→[14:12] (R, I, S, B); rs2→[24:20] (R, S, B). R: [31:25]={1'b0,f7b5,5'b0}. Unused fields are zero.
- Immediates: I: [31:20]=imm[11:0]. S: [31:25]=imm[11:5], [11:7]=imm[4:0]. B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11]. U: [31:12]=imm[31:12]. J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
- For I-arith, bit 30 comes from imm[10]. The caller sets imm[10] for srai.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE→RUN on start with prog_len≠0. Sample base_addr/prog_len, clear accepted count, write pointer, err and err_cnt.
  - IDLE→DONE on start with prog_len=0.
  - RUN→DRAIN when accepted count reaches prog_len.
  - DRAIN→DONE when the output register is empty.
  - DONE→IDLE unconditionally. done=1 only in DONE.
- in_ready = (state==RUN) && (accepted<prog_len) && (!out_valid || out_ready). It is low in every other state.
- One-entry output register. An accepted request loads out_data and out_addr=base_addr+wr_ptr, then increments wr_ptr. A new word may load in the same cycle the current word is consumed.
- start pulses while busy are ignored.
- Reset at any point forces IDLE, clears all counters and the output register, and discards in-flight words.

## Timing
- Reset values: in_ready=0, out_valid=0, out_data=0, out_addr=0, busy=0, done=0, err=0, err_cnt=0.
- Latency: request accepted at edge N → out_valid=1 from edge N onward (visible in cycle N+1).
- Throughput is one word per cycle while out_ready=1.
- While out_valid && !out_ready, out_data and out_addr are held stable.
- start at edge N → busy=1 and in_ready may assert in cycle N+1.
- For prog_len=0, done pulses in cycle N+1 and busy returns to 0 in cycle N+2.
- done asserts the cycle after the last word handshakes. busy drops one cycle after done.
- Address wrap: base_addr=2^ADDR_W−1 gives out_addr sequence 2^ADDR_W−1, 0, 1, …

## Configuration
- IMM_CHECK_EN defined: imm is range-checked per format.
  - I/S: imm[31:11] all equal.
  - B: imm[31:12] all equal and imm[0]=0.
  - J: imm[31:20] all equal and imm[0]=0.
  - U: imm[11:0]=0.
  - R: never fails.
  - A failing request is accepted (counts toward prog_len) but is not emitted and consumes no address. It sets err and increments err_cnt, saturating at 255.
- IMM_CHECK_EN undefined: no check; out-of-range bits are silently truncated; err and err_cnt are tied to 0.

## Test plan
- addi: start base=0, len=1; fmt=1, rd=1, rs1=0, f3=0, imm=5 → out_data=0x00500093, out_addr=0; done pulses one cycle after the handshake.
- Stream of four, out_ready=1: sw (fmt=3, rs1=1, rs2=2, f3=2, imm=8), beq (fmt=6, rs1=1, rs2=2, f3=0, imm=−4), lui (fmt=4, rd=5, imm=0x12345000), jal (fmt=7, rd=1, imm=8) → 0x0020A423, 0xFE208EE3, 0x123452B7, 0x008000EF on consecutive cycles, addrs 0x10–0x13 for base=0x10.
- Backpressure: hold out_ready=0 for 3 cycles with a word pending → out_data/out_addr stable, in_ready=0; release → word consumed, next request accepted the same cycle.
- Wrap and zero length: base=0xFF, len=2 → out_addr 0xFF then 0x00. start with len=0 → done in cycle N+1, no out_valid.
- IMM_CHECK_EN: addi imm=4096 then addi imm=1 with base=0 → first dropped, err=1, err_cnt=1; second emitted at out_addr=0. Without the macro → 0x00000093 emitted at addr 0.
- Reset mid-RUN with out_valid=1 → next cycle all outputs at reset values; a start pulse issued while busy has no effect.
